relay_bbm_driver: RTL and testbench

- Downstream stage of the antenna-array relay channel sequencer: accepts each 21-bit relay pattern (7 Teledyne relays x 3 control pins, active-low, 3'b111 = relay off) and drives the physical relay pins.
- Enforces break-before-make per relay, waits a settling time and flags when RF paths are valid for sampling.
- Runs a watchdog that forces all relays off if the sequencer stops updating.

---
 rtl/relay_pkg.sv | 25 ++
 rtl/relay_bbm_driver_if.sv | 23 ++
 rtl/relay_timer.sv | 42 ++++
 rtl/relay_bbm_driver.sv | 152 +++++++++++++++
 tb/tb_relay_bbm_driver.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/relay_pkg.sv
// Shared constants and state type for the relay break-before-make driver.
package relay_pkg;

  localparam int N_RELAYS  = 7;
  localparam int PINS      = 3;
  localparam int PATTERN_W = N_RELAYS * PINS;

  localparam logic [PINS-1:0]      OFF_CODE = 3'b111;
  localparam logic [PATTERN_W-1:0] ALL_OFF  = '1;

  typedef enum logic [2:0] {
    IDLE,
    BREAK,
    MAKE,
    HOLD,
    FAULT
  } relay_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/relay_bbm_driver_if.sv
// Pattern handshake and relay drive/status bundle between sequencer and driver.
interface relay_bbm_driver_if
  import relay_pkg::*;
();
  logic [PATTERN_W-1:0] pattern_in;
  logic                 pattern_valid;
  logic                 pattern_ready;
  logic [PATTERN_W-1:0] relay_out;
  logic                 settled;
  logic                 overrun;
  logic                 fault;
  logic [15:0]          switch_count;

  modport master (
    output pattern_in, pattern_valid,
    input  pattern_ready, relay_out, settled, overrun, fault, switch_count
  );

  modport slave (
    input  pattern_in, pattern_valid,
    output pattern_ready, relay_out, settled, overrun, fault, switch_count
  );
endinterface

// File: rtl/relay_timer.sv
// Loadable down-counter: start loads a cycle count, done pulses in the last cycle.
module relay_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             clear,
  input  logic             start,
  input  logic [CNT_W-1:0] load_value,
  output logic             done
);
  logic [CNT_W-1:0] count_q, count_d;
  logic             running_q, running_d;

  always_comb begin
    count_d   = count_q;
    running_d = running_q;
    if (clear) begin
      count_d   = '0;
      running_d = 1'b0;
    end else if (start) begin
      count_d   = load_value;
      running_d = 1'b1;
    end else if (running_q) begin
      count_d   = count_q - CNT_W'(1);
      running_d = (count_q != CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_q   <= '0;
      running_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      running_q <= running_d;
    end
  end

  // done lands on the cycle before the edge that completes load_value cycles
  assign done = running_q && (count_q == CNT_W'(1));
endmodule

// File: rtl/relay_bbm_driver.sv
// Drives relay pins with per-relay break-before-make, settle flag and a HOLD watchdog.
module relay_bbm_driver
  import relay_pkg::*;
#(
  parameter int BREAK_CYCLES  = 100000,
  parameter int SETTLE_CYCLES = 200000,
  parameter int WDOG_CYCLES   = 5000000
) (
  input  logic               clk_in,
  input  logic               rst,
  relay_bbm_driver_if.slave  bus
);
  localparam int CNT_W = $clog2(max3(BREAK_CYCLES, SETTLE_CYCLES, WDOG_CYCLES) + 1);
  localparam logic [CNT_W-1:0] BREAK_LOAD  = CNT_W'(BREAK_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] WDOG_LOAD   = CNT_W'(WDOG_CYCLES);

  relay_state_e         state_q, state_d;
  logic [PATTERN_W-1:0] relay_out_q, relay_out_d;
  logic [PATTERN_W-1:0] pending_q, pending_d;
  logic                 settled_q, settled_d;
  logic                 ready_q, ready_d;
  logic                 overrun_q, overrun_d;
  logic                 fault_q, fault_d;
  logic [15:0]          switch_count_q, switch_count_d;

  logic                 accept;
  logic [N_RELAYS-1:0]  change_mask;
  logic [PATTERN_W-1:0] break_image;
  logic                 phase_start, phase_done;
  logic [CNT_W-1:0]     phase_load;
  logic                 wdog_start, wdog_clear, wdog_done;

  assign accept = bus.pattern_valid && ready_q;

  // Changed relays go off during the break; untouched relays keep their code.
  for (genvar gi = 0; gi < N_RELAYS; gi++) begin : g_grp
    assign change_mask[gi] = bus.pattern_in[gi*PINS +: PINS] != relay_out_q[gi*PINS +: PINS];
    assign break_image[gi*PINS +: PINS] =
      change_mask[gi] ? OFF_CODE : relay_out_q[gi*PINS +: PINS];
  end

  always_comb begin
    state_d        = state_q;
    relay_out_d    = relay_out_q;
    pending_d      = pending_q;
    settled_d      = settled_q;
    fault_d        = fault_q;
    switch_count_d = switch_count_q;
    overrun_d      = bus.pattern_valid && !ready_q;
    phase_start    = 1'b0;
    phase_load     = BREAK_LOAD;
    wdog_start     = 1'b0;
    wdog_clear     = 1'b0;

    case (state_q)
      IDLE, HOLD, FAULT: begin
        if (accept) begin
          pending_d = bus.pattern_in;
          fault_d   = 1'b0;
          if (change_mask != '0) begin
            state_d        = BREAK;
            relay_out_d    = break_image;
            settled_d      = 1'b0;
            switch_count_d = switch_count_q + 16'd1;
            phase_start    = 1'b1;
            phase_load     = BREAK_LOAD;
            wdog_clear     = 1'b1;
          end else begin
            state_d    = HOLD;
            settled_d  = 1'b1;
            wdog_start = 1'b1;
          end
        end else if (state_q == HOLD && wdog_done) begin
          state_d     = FAULT;
          relay_out_d = ALL_OFF;
          settled_d   = 1'b0;
          fault_d     = 1'b1;
        end
      end
      BREAK: begin
        if (phase_done) begin
          state_d     = MAKE;
          relay_out_d = pending_q;
          phase_start = 1'b1;
          phase_load  = SETTLE_LOAD;
        end
      end
      MAKE: begin
        if (phase_done) begin
          state_d    = HOLD;
          settled_d  = 1'b1;
          wdog_start = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        relay_out_d = ALL_OFF;
        settled_d   = 1'b0;
      end
    endcase

    ready_d = (state_d == IDLE) || (state_d == HOLD) || (state_d == FAULT);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q        <= IDLE;
      relay_out_q    <= ALL_OFF;
      pending_q      <= ALL_OFF;
      settled_q      <= 1'b0;
      ready_q        <= 1'b1;
      overrun_q      <= 1'b0;
      fault_q        <= 1'b0;
      switch_count_q <= '0;
    end else begin
      state_q        <= state_d;
      relay_out_q    <= relay_out_d;
      pending_q      <= pending_d;
      settled_q      <= settled_d;
      ready_q        <= ready_d;
      overrun_q      <= overrun_d;
      fault_q        <= fault_d;
      switch_count_q <= switch_count_d;
    end
  end

  relay_timer #(.CNT_W(CNT_W)) u_phase_timer (
    .clk        (clk_in),
    .srst       (rst),
    .clear      (1'b0),
    .start      (phase_start),
    .load_value (phase_load),
    .done       (phase_done)
  );

  relay_timer #(.CNT_W(CNT_W)) u_wdog_timer (
    .clk        (clk_in),
    .srst       (rst),
    .clear      (wdog_clear),
    .start      (wdog_start),
    .load_value (WDOG_LOAD),
    .done       (wdog_done)
  );

  assign bus.relay_out     = relay_out_q;
  assign bus.settled       = settled_q;
  assign bus.pattern_ready = ready_q;
  assign bus.overrun       = overrun_q;
  assign bus.fault         = fault_q;
  assign bus.switch_count  = switch_count_q;
endmodule

// File: tb/tb_relay_bbm_driver.sv
// Directed vector table plus randomized traffic against a timestamp-based reference model.
module tb_relay_bbm_driver;
  import relay_pkg::*;

  localparam int B = 4;
  localparam int S = 8;
  localparam int W = 64;

  localparam logic [20:0] P1  = 21'b000_000_111_111_000_111_111;
  localparam logic [20:0] P2  = 21'b000_000_111_111_111_111_111;
  localparam logic [20:0] OFF = 21'h1FFFFF;

  logic clk_in = 1'b0;
  logic rst    = 1'b0;
  always #5 clk_in = ~clk_in;

  relay_bbm_driver_if bus();

  relay_bbm_driver #(
    .BREAK_CYCLES  (B),
    .SETTLE_CYCLES (S),
    .WDOG_CYCLES   (W)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: outputs derived from absolute edge numbers of scheduled events.
  longint      edge_no     = 0;
  longint      make_edge   = -1;
  longint      settle_edge = -1;
  longint      wd_deadline = -1;
  logic [20:0] m_out       = OFF;
  logic [20:0] m_target    = OFF;
  bit          m_settled   = 0;
  bit          m_ready     = 1;
  bit          m_overrun   = 0;
  bit          m_fault     = 0;
  logic [15:0] m_count     = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d actual=0x%0h required=0x%0h", name, edge_no, act, exp);
    end
  endtask

  task automatic model_edge(bit r, bit v, logic [20:0] p);
    bit any_change;
    edge_no++;
    if (r) begin
      m_out = OFF; m_target = OFF; m_settled = 0; m_ready = 1;
      m_overrun = 0; m_fault = 0; m_count = 0;
      make_edge = -1; settle_edge = -1; wd_deadline = -1;
      return;
    end
    m_overrun = v && !m_ready;
    if (v && m_ready) begin
      m_fault    = 0;
      any_change = 0;
      for (int i = 0; i < N_RELAYS; i++) begin
        if (p[3*i +: 3] != m_out[3*i +: 3]) begin
          any_change     = 1;
          m_out[3*i +: 3] = 3'b111;
        end
      end
      if (any_change) begin
        m_count     = m_count + 16'd1;
        m_target    = p;
        make_edge   = edge_no + B;
        settle_edge = edge_no + B + S;
        m_settled   = 0;
        wd_deadline = -1;
      end else begin
        m_settled   = 1;
        wd_deadline = edge_no + W;
      end
    end else begin
      if (edge_no == make_edge) m_out = m_target;
      if (edge_no == settle_edge) begin
        m_settled   = 1;
        wd_deadline = edge_no + W;
      end
      if (edge_no == wd_deadline) begin
        m_out       = OFF;
        m_settled   = 0;
        m_fault     = 1;
        wd_deadline = -1;
      end
    end
    m_ready = (edge_no >= settle_edge);
  endtask

  task automatic check_model();
    chk("model relay_out", 32'(bus.relay_out), 32'(m_out));
    chk("model settled", 32'(bus.settled), 32'(m_settled));
    chk("model pattern_ready", 32'(bus.pattern_ready), 32'(m_ready));
    chk("model overrun", 32'(bus.overrun), 32'(m_overrun));
    chk("model fault", 32'(bus.fault), 32'(m_fault));
    chk("model switch_count", 32'(bus.switch_count), 32'(m_count));
  endtask

  task automatic step(bit r, bit v, logic [20:0] p);
    rst               = r;
    bus.pattern_valid = v;
    bus.pattern_in    = p;
    @(posedge clk_in);
    model_edge(r, v, p);
    #1;
    check_model();
  endtask

  typedef struct {
    bit          r;
    bit          v;
    logic [20:0] p;
    int          n;
    logic [20:0] e_out;
    bit          e_settled;
    bit          e_ready;
    bit          e_ovr;
    bit          e_fault;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [20:0] pat;
    int          vprob;

    bus.pattern_valid = 1'b0;
    bus.pattern_in    = '0;

    //             r  v  pattern n   relay_out set rdy ovr flt cnt
    vecs.push_back('{1, 0, 21'h0, 1,  OFF, 0, 1, 0, 0, 16'd0});
    vecs.push_back('{0, 0, 21'h0, 1,  OFF, 0, 1, 0, 0, 16'd0});
    vecs.push_back('{0, 1, P1,    1,  OFF, 0, 0, 0, 0, 16'd1});
    vecs.push_back('{0, 0, 21'h0, 2,  OFF, 0, 0, 0, 0, 16'd1});
    vecs.push_back('{0, 1, P2,    1,  OFF, 0, 0, 1, 0, 16'd1});
    vecs.push_back('{0, 0, 21'h0, 1,  P1,  0, 0, 0, 0, 16'd1});
    vecs.push_back('{0, 0, 21'h0, 7,  P1,  0, 0, 0, 0, 16'd1});
    vecs.push_back('{0, 0, 21'h0, 1,  P1,  1, 1, 0, 0, 16'd1});
    vecs.push_back('{0, 0, 21'h0, 30, P1,  1, 1, 0, 0, 16'd1});
    vecs.push_back('{0, 1, P1,    1,  P1,  1, 1, 0, 0, 16'd1});
    vecs.push_back('{0, 0, 21'h0, 40, P1,  1, 1, 0, 0, 16'd1});
    vecs.push_back('{0, 1, P2,    1,  P2,  0, 0, 0, 0, 16'd2});
    vecs.push_back('{0, 0, 21'h0, 3,  P2,  0, 0, 0, 0, 16'd2});
    vecs.push_back('{0, 0, 21'h0, 1,  P2,  0, 0, 0, 0, 16'd2});
    vecs.push_back('{0, 0, 21'h0, 8,  P2,  1, 1, 0, 0, 16'd2});
    vecs.push_back('{0, 0, 21'h0, 63, P2,  1, 1, 0, 0, 16'd2});
    vecs.push_back('{0, 0, 21'h0, 1,  OFF, 0, 1, 0, 1, 16'd2});
    vecs.push_back('{0, 1, P1,    1,  OFF, 0, 0, 0, 0, 16'd3});
    vecs.push_back('{0, 0, 21'h0, 4,  P1,  0, 0, 0, 0, 16'd3});
    vecs.push_back('{0, 0, 21'h0, 2,  P1,  0, 0, 0, 0, 16'd3});
    vecs.push_back('{1, 0, 21'h0, 1,  OFF, 0, 1, 0, 0, 16'd0});
    vecs.push_back('{0, 1, OFF,   1,  OFF, 1, 1, 0, 0, 16'd0});
    vecs.push_back('{0, 0, 21'h0, 63, OFF, 1, 1, 0, 0, 16'd0});
    vecs.push_back('{0, 1, OFF,   1,  OFF, 1, 1, 0, 0, 16'd0});
    vecs.push_back('{0, 0, 21'h0, 63, OFF, 1, 1, 0, 0, 16'd0});
    vecs.push_back('{0, 0, 21'h0, 1,  OFF, 0, 1, 0, 1, 16'd0});

    foreach (vecs[k]) begin
      for (int c = 0; c < vecs[k].n; c++) begin
        if (c == 0) step(vecs[k].r, vecs[k].v, vecs[k].p);
        else        step(1'b0, 1'b0, vecs[k].p);
      end
      chk($sformatf("row%0d relay_out", k), 32'(bus.relay_out), 32'(vecs[k].e_out));
      chk($sformatf("row%0d settled", k), 32'(bus.settled), 32'(vecs[k].e_settled));
      chk($sformatf("row%0d pattern_ready", k), 32'(bus.pattern_ready), 32'(vecs[k].e_ready));
      chk($sformatf("row%0d overrun", k), 32'(bus.overrun), 32'(vecs[k].e_ovr));
      chk($sformatf("row%0d fault", k), 32'(bus.fault), 32'(vecs[k].e_fault));
      chk($sformatf("row%0d switch_count", k), 32'(bus.switch_count), 32'(vecs[k].e_cnt));
      $display("row %0d r=%0b v=%0b pat=%06h n=%0d -> relay_out=%06h settled=%0b fault=%0b count=%0d",
               k, vecs[k].r, vecs[k].v, vecs[k].p, vecs[k].n,
               bus.relay_out, bus.settled, bus.fault, bus.switch_count);
    end

    // Random traffic with varying request density so the watchdog also fires.
    for (int seg = 0; seg < 6; seg++) begin
      case (seg % 3)
        0:       vprob = 3;
        1:       vprob = 20;
        default: vprob = 90;
      endcase
      for (int c = 0; c < 500; c++) begin
        for (int i = 0; i < N_RELAYS; i++) begin
          case ($urandom_range(0, 3))
            0:       pat[3*i +: 3] = 3'b111;
            1:       pat[3*i +: 3] = 3'($urandom);
            default: pat[3*i +: 3] = m_out[3*i +: 3];
          endcase
        end
        if ($urandom_range(0, 499) == 0) begin
          $display("rand edge=%0d reset", edge_no + 1);
          step(1'b1, 1'b0, pat);
        end else if ($urandom_range(0, vprob - 1) == 0) begin
          $display("rand edge=%0d valid pat=%06h ready=%0b", edge_no + 1, pat, m_ready);
          step(1'b0, 1'b1, pat);
        end else begin
          step(1'b0, 1'b0, pat);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
